sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 105 ++++++++++
 tb/tb_sipo_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out frame receiver: skips SKIP_BITS cycles after a start
// strobe, shifts in WIDTH payload bits MSB first, then hands the word off with valid/ready.
module sipo_rx #(
    parameter int WIDTH     = 42,
    parameter int SKIP_BITS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             serial_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // A zero-width skip counter is illegal, so keep at least one bit when SKIP_BITS is 0.
    localparam int SKIP_W = (SKIP_BITS > 0) ? $clog2(SKIP_BITS + 1) : 1;
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_BITS);
    localparam logic [BIT_W-1:0]  BIT_INIT  = BIT_W'(WIDTH);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    state_t             state;
    logic [SKIP_W-1:0]  skip_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shift_next;

    // Left shift with the new bit entering at the LSB; the cast keeps it legal for WIDTH=1.
    assign shift_next = WIDTH'({shreg, serial_in});

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the block deliberately override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (start) begin
                // A start during a frame, including its completion edge, abandons that frame.
                frame_err <= (state != IDLE);
                skip_cnt  <= SKIP_INIT;
                bit_cnt   <= BIT_INIT;
                shreg     <= '0;
                busy      <= 1'b1;
                if (SKIP_BITS == 0) begin
                    state <= SHIFT;
                end else begin
                    state <= SKIP;
                end
            end else begin
                case (state)
                    IDLE: ;
                    SKIP: begin
                        skip_cnt <= skip_cnt - SKIP_ONE;
                        if (skip_cnt == SKIP_ONE) begin
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        shreg   <= shift_next;
                        bit_cnt <= bit_cnt - BIT_ONE;
                        if (bit_cnt == BIT_ONE) begin
                            data_out  <= shift_next;
                            out_valid <= 1'b1;
                            overrun   <= out_valid && !out_ready;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed-plus-random bench for sipo_rx; a transaction-level model tracks the
// pending output word and predicts valid, overrun and frame_err per cycle.
module tb_sipo_rx;

    localparam int W = 42;
    localparam int S = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         serial_in;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the word held for the consumer and whether a frame is open.
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_busy;

    sipo_rx #(.WIDTH(W), .SKIP_BITS(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .serial_in (serial_in),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hold(input logic exp_busy);
        check("busy", busy, exp_busy);
        check("out_valid", out_valid, m_valid);
        check("data_out", data_out, m_data);
        check("overrun_idle", overrun, 1'b0);
        check("frame_err_idle", frame_err, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            start     = 1'b0;
            serial_in = 1'($urandom_range(0, 1));
            out_ready = rdy;
            step();
            if (rdy) m_valid = 1'b0;
            check_hold(1'b0);
        end
    endtask

    // Starts a frame and abandons it after n edges in total (start edge included).
    task automatic partial(input int n);
        logic was_busy;
        was_busy  = m_busy;
        start     = 1'b1;
        out_ready = 1'b0;
        serial_in = 1'($urandom_range(0, 1));
        step();
        start  = 1'b0;
        m_busy = 1'b1;
        check("partial_frame_err", frame_err, was_busy);
        for (int k = 1; k < n; k++) begin
            serial_in = 1'($urandom_range(0, 1));
            step();
            check_hold(1'b1);
        end
    endtask

    // Full frame: start edge, S ignored cycles, then W payload bits MSB first.
    task automatic run_frame(input logic [W-1:0] word, input logic rdy, input logic rdy_last);
        logic was_busy;
        logic exp_ovr;
        was_busy  = m_busy;
        start     = 1'b1;
        out_ready = rdy;
        serial_in = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        if (rdy) m_valid = 1'b0;
        m_busy = 1'b1;
        check("start_frame_err", frame_err, was_busy);
        check("start_busy", busy, 1'b1);
        check("start_valid", out_valid, m_valid);
        for (int k = 0; k < S; k++) begin
            serial_in = 1'($urandom_range(0, 1));
            step();
            if (rdy) m_valid = 1'b0;
            check_hold(1'b1);
        end
        for (int i = W - 1; i >= 0; i--) begin
            serial_in = word[i];
            out_ready = (i == 0) ? rdy_last : rdy;
            step();
            if (i > 0) begin
                if (rdy) m_valid = 1'b0;
                check_hold(1'b1);
            end else begin
                exp_ovr = m_valid && !rdy_last;
                m_valid = 1'b1;
                m_data  = word;
                m_busy  = 1'b0;
                check("done_valid", out_valid, 1'b1);
                check("done_data", data_out, word);
                check("done_overrun", overrun, exp_ovr);
                check("done_busy", busy, 1'b0);
                check("done_frame_err", frame_err, 1'b0);
            end
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_busy    = 1'b0;

        #1;
        check("rst_data", data_out, '0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1);

        // Basic frame: valid for exactly one cycle when the consumer is ready.
        run_frame(42'h2A5_5A5A_F00D, 1'b1, 1'b1);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Backpressure: second completion overwrites and pulses overrun.
        run_frame(42'h1, 1'b0, 1'b0);
        run_frame(42'h3FF_FFFF_FFFF, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(1, 1'b1);

        // Acceptance on the completion edge: new word, no overrun.
        run_frame(rand_word(), 1'b0, 1'b0);
        run_frame(rand_word(), 1'b0, 1'b1);
        idle(1, 1'b1);

        // Restart at E0+20, then a start landing exactly on the completion edge.
        partial(20);
        run_frame(rand_word(), 1'b1, 1'b1);
        idle(2, 1'b1);
        partial(S + W);
        run_frame(rand_word(), 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset mid-frame with an unconsumed word pending.
        run_frame(rand_word(), 1'b0, 1'b0);
        partial(30);
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_busy  = 1'b0;
        check("mid_rst_data", data_out, '0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(S + W + 5, 1'b1);
        run_frame(rand_word(), 1'b1, 1'b1);

        // Random words with random consumer behaviour and idle gaps.
        for (int f = 0; f < 100; f++) begin
            run_frame(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
